// File: rtl/axi_ads868x_pkg.sv
// rtl/axi_ads868x_pkg.sv - shared types and constants for the ADS868x AXI4-Lite to up-bus bridge
//
// Purpose: write/read FSM state encodings, AXI response codes and the data
// word returned when a read times out.
package axi_ads868x_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_WAIT,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_RESP
    } rd_state_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/axi_ads868x_up_timeout.sv
// rtl/axi_ads868x_up_timeout.sv - ack-wait cycle counter for one up-bus channel
//
// Purpose: counts the cycles a channel spends waiting for an ack.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : clear the count (issued in the request cycle)
//   en_i       : count this cycle (channel is waiting for an ack)
//   done_o     : this is the C_TIMEOUT-th waiting cycle since the last load
module axi_ads868x_up_timeout #(
    parameter int unsigned C_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [16:0] cnt_inc;

    // done fires while the counter steps onto C_TIMEOUT, so the waiting
    // state lasts exactly C_TIMEOUT cycles before the error response.
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    assign done_o  = en_i && (cnt_inc == 17'(C_TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !done_o) begin
            cnt_d = cnt_inc[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_ads868x_up_axi.sv
// rtl/axi_ads868x_up_axi.sv - AXI4-Lite slave driving the ADS868x up_* request/ack register bus
//
// Purpose: turns AXI4-Lite writes/reads into one-cycle up_wr_req/up_rd_req
// pulses, waits for the bank ack and answers OKAY, or SLVERR after C_TIMEOUT
// waiting cycles. Write and read channels are fully independent.
// Ports:
//   up_clk, up_rstn          : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*          : AXI4-Lite write address, data, response
//   s_axi_ar*/r*             : AXI4-Lite read address, data/response
//   up_wr_addr/req/be/data   : write request to the bank, up_wr_ack back
//   up_rd_addr/req           : read request to the bank, up_rd_data/ack back
module axi_ads868x_up_axi
    import axi_ads868x_pkg::*;
#(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
    parameter int unsigned C_TIMEOUT          = 255
) (
    input  logic                          up_clk,
    input  logic                          up_rstn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [9:0]                    up_wr_addr,
    output logic                          up_wr_req,
    output logic [3:0]                    up_wr_be,
    output logic [31:0]                   up_wr_data,
    input  logic                          up_wr_ack,
    output logic [9:0]                    up_rd_addr,
    output logic                          up_rd_req,
    input  logic [31:0]                   up_rd_data,
    input  logic                          up_rd_ack
);

    // Byte-lane bits of the AXI addresses carry no information for a word bank.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e   wr_state_q, wr_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [9:0]  aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        up_wr_req_q, up_wr_req_d;
    logic [9:0]  up_wr_addr_q, up_wr_addr_d;
    logic [3:0]  up_wr_be_q, up_wr_be_d;
    logic [31:0] up_wr_data_q, up_wr_data_d;
    logic        wr_to_load, wr_to_en, wr_to_done;

    axi_ads868x_up_timeout #(.C_TIMEOUT(C_TIMEOUT)) i_wr_timeout (
        .clk    (up_clk),
        .rst_n  (up_rstn),
        .load_i (wr_to_load),
        .en_i   (wr_to_en),
        .done_o (wr_to_done)
    );

    always_comb begin
        wr_state_d   = wr_state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        aw_addr_d    = aw_addr_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bresp_d      = bresp_q;
        up_wr_addr_d = up_wr_addr_q;
        up_wr_be_d   = up_wr_be_q;
        up_wr_data_d = up_wr_data_q;
        wr_to_load   = 1'b0;
        wr_to_en     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = s_axi_awaddr[11:2];
                end
                if (s_axi_wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    w_data_d = s_axi_wdata;
                    w_strb_d = s_axi_wstrb;
                end
                // Uses the next-state holds so AW and W in the same cycle
                // still request on the following cycle.
                if (aw_held_d && w_held_d) begin
                    wr_state_d   = W_REQ;
                    up_wr_addr_d = aw_addr_d;
                    up_wr_be_d   = w_strb_d;
                    up_wr_data_d = w_data_d;
                end
            end
            W_REQ: begin
                wr_to_load = 1'b1;
                wr_state_d = W_WAIT;
            end
            W_WAIT: begin
                wr_to_en = 1'b1;
                if (up_wr_ack) begin
                    bresp_d    = RESP_OKAY;
                    wr_state_d = W_RESP;
                end else if (wr_to_done) begin
                    bresp_d    = RESP_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        awready_d   = (wr_state_d == W_IDLE) && !aw_held_d;
        wready_d    = (wr_state_d == W_IDLE) && !w_held_d;
        bvalid_d    = (wr_state_d == W_RESP);
        up_wr_req_d = (wr_state_d == W_REQ);
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wr_state_q   <= W_IDLE;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            up_wr_req_q  <= 1'b0;
            up_wr_addr_q <= '0;
            up_wr_be_q   <= '0;
            up_wr_data_q <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            aw_addr_q    <= aw_addr_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            up_wr_req_q  <= up_wr_req_d;
            up_wr_addr_q <= up_wr_addr_d;
            up_wr_be_q   <= up_wr_be_d;
            up_wr_data_q <= up_wr_data_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign up_wr_req     = up_wr_req_q;
    assign up_wr_addr    = up_wr_addr_q;
    assign up_wr_be      = up_wr_be_q;
    assign up_wr_data    = up_wr_data_q;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e   rd_state_q, rd_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        up_rd_req_q, up_rd_req_d;
    logic [9:0]  up_rd_addr_q, up_rd_addr_d;
    logic        rd_to_load, rd_to_en, rd_to_done;

    axi_ads868x_up_timeout #(.C_TIMEOUT(C_TIMEOUT)) i_rd_timeout (
        .clk    (up_clk),
        .rst_n  (up_rstn),
        .load_i (rd_to_load),
        .en_i   (rd_to_en),
        .done_o (rd_to_done)
    );

    always_comb begin
        rd_state_d   = rd_state_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        up_rd_addr_d = up_rd_addr_q;
        rd_to_load   = 1'b0;
        rd_to_en     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    up_rd_addr_d = s_axi_araddr[11:2];
                    rd_state_d   = R_REQ;
                end
            end
            R_REQ: begin
                rd_to_load = 1'b1;
                rd_state_d = R_WAIT;
            end
            R_WAIT: begin
                rd_to_en = 1'b1;
                if (up_rd_ack) begin
                    rdata_d    = up_rd_data;
                    rresp_d    = RESP_OKAY;
                    rd_state_d = R_RESP;
                end else if (rd_to_done) begin
                    rdata_d    = TIMEOUT_RDATA;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d   = (rd_state_d == R_IDLE);
        rvalid_d    = (rd_state_d == R_RESP);
        up_rd_req_d = (rd_state_d == R_REQ);
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            rd_state_q   <= R_IDLE;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            up_rd_req_q  <= 1'b0;
            up_rd_addr_q <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            up_rd_req_q  <= up_rd_req_d;
            up_rd_addr_q <= up_rd_addr_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign up_rd_req     = up_rd_req_q;
    assign up_rd_addr    = up_rd_addr_q;

endmodule

// File: doc/axi_ads868x_up_axi.md
# axi_ads868x_up_axi

AXI4-Lite slave that converts host register accesses into the single-cycle `up_*` request/ack bus, acting as the initiator for the ADS868x register bank. It sits between the processor interconnect and the register bank in the `up_clk` domain. Write and read channels run independently. A per-channel timeout guarantees an AXI response even when the bank never acks.

## Interface

Parameters:
- `C_S_AXI_ADDR_WIDTH`, default 12: AXI byte-address width. Word address is `[11:2]`; higher bits are ignored.
- `C_TIMEOUT`, default 255: cycles to wait for an ack before answering SLVERR. Range 1..65535.

Ports:
- `up_clk`  in  1: single clock for everything.
- `up_rstn`  in  1: reset, asynchronous assert, active-low.
- `s_axi_awaddr`  in  C_S_AXI_ADDR_WIDTH: write address.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1: write-address handshake.
- `s_axi_wdata`  in  32, `s_axi_wstrb`  in  4: write data and byte strobes.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1: write-data handshake.
- `s_axi_bresp`  out  2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response.
- `s_axi_araddr`  in  C_S_AXI_ADDR_WIDTH: read address.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1: read-address handshake.
- `s_axi_rdata`  out  32, `s_axi_rresp`  out  2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data and response.
- `up_wr_addr`  out  10, `up_wr_req`  out  1, `up_wr_be`  out  4, `up_wr_data`  out  32: write request to the bank.
- `up_wr_ack`  in  1: write ack from the bank.
- `up_rd_addr`  out  10, `up_rd_req`  out  1: read request to the bank.
- `up_rd_data`  in  32, `up_rd_ack`  in  1: read data and ack from the bank.

## Operation

- **Write FSM states:** `W_IDLE`, `W_REQ`, `W_WAIT`, `W_RESP`.
- **W_IDLE:**
  - `awready` is high until AW is captured; `wready` is high until W is captured. The two may arrive in either order or in the same cycle.
  - Each capture latches its payload and drops its own ready.
  - When both are held, go to `W_REQ`.
- **W_REQ:** `up_wr_req` = 1 for exactly one cycle. `up_wr_addr` = `awaddr[11:2]`, with be and data from the latches. Clear the timeout counter, then go to `W_WAIT`.
- **W_WAIT:**
  - On `up_wr_ack`: `bresp` = OKAY (2'b00), go to `W_RESP`.
  - If the counter reaches `C_TIMEOUT` first: `bresp` = SLVERR (2'b10), go to `W_RESP`.
  - If ack and timeout fall in the same cycle, ack wins (OKAY).
- **W_RESP:** `bvalid` = 1 and is held until `bready`. Then clear the latches and return to `W_IDLE`.
- **Read FSM states:** `R_IDLE` (`arready` = 1), `R_REQ` (`up_rd_req` one cycle), `R_WAIT`, `R_RESP`.
  - On `up_rd_ack`, capture `up_rd_data`; `rresp` = OKAY.
  - On timeout, `rdata` = 32'hDEADBEEF and `rresp` = SLVERR.
  - `rvalid` is held until `rready`.
- **Stray acks:** `up_*_ack` is honoured only in `*_WAIT`. Acks in any other state, including late acks after a timeout, are ignored.
- **Channel independence:** read and write run concurrently with no ordering between them.
- **Address and protection:** the `up_*_addr` and data outputs hold their values outside the req cycle. AXI prot is not supported; unaligned low address bits are ignored.

## Timing

- **Reset values:** all readies, `bvalid`, `rvalid`, `up_wr_req`, `up_rd_req` = 0. Address, data and resp outputs = 0. Both FSMs start in IDLE.
- **Ready after reset:** `awready`, `wready` and `arready` are registered. They go to 1 on the first `up_clk` edge after `up_rstn` rises.
- **Write latency:** AW+W handshake at cycle T. `up_wr_req` at T+1. With the bank acking at T+2, `bvalid` is at T+3. Minimum write cycle is 4 clocks per transaction including `bready` at T+3.
- **Read latency:** AR handshake at T. `up_rd_req` at T+1. Ack with data at T+2. `rvalid` with `rdata` at T+3.
- **Timeout:** with no ack, SLVERR valid appears `C_TIMEOUT`+2 cycles after the handshake.
- **Reset mid-operation:** asynchronous return to reset values. Any in-flight transaction is dropped with no response.

## Structure

- **Package `axi_ads868x_pkg`:** write/read state enums, the `RESP_OKAY` and `RESP_SLVERR` constants, and the timeout data value 32'hDEADBEEF.
- **Sub-module `axi_ads868x_up_timeout`:** load/enable counter with a `done` flag when it reaches `C_TIMEOUT`. It is instantiated once per channel.
- The two FSMs live in the top module.

## Test plan

- **Write then read back:** AW 0x004 and W 0x0000_0001/strb 0xF in the same cycle, bank acks after 1 cycle.
  - Expect `up_wr_addr` = 1, `up_wr_req` one pulse, `bresp` = 0 at T+3.
  - Read 0x000 returning 0x2019_1230 → `rdata` 0x2019_1230, `rresp` 0.
- **AW/W ordering:** W presented 5 cycles before AW → exactly one `up_wr_req`, asserted the cycle after the AW handshake; `wready` low while W is held.
- **No write ack, `C_TIMEOUT` = 8:** write → `bvalid` with `bresp` 2'b10 at handshake+10. A late ack at +12 has no effect; the next write proceeds normally.
- **Read timeout:** → `rdata` 0xDEADBEEF, `rresp` 2'b10. `rready` held low 20 cycles → `rvalid` and `rdata` stay stable.
- **Concurrent access:** write and read issued in the same cycle with distinct addresses → both up requests at T+1, both responses correct and independent.
- **Reset mid-operation:** `up_rstn` asserted during `W_WAIT` → all outputs are 0 immediately; after release, readies go to 1 one cycle later and a new write completes with OKAY.
